// File: rtl/mem_wb_stage.sv
// MIPS32 memory-access stage: internal word RAM load/store, writeback select,
// and the MEM/WB pipeline register feeding the register file.
module mem_wb_stage #(
  parameter int ADDR_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        imem_read,
  input  logic        imem_write,
  input  logic        imem_to_reg,
  input  logic        ipc_to_reg,
  input  logic        ireg_write,
  input  logic [31:0] iPC,
  input  logic [31:0] iIR,
  input  logic [31:0] ialu_res,
  input  logic [31:0] iData_forMem,
  input  logic [4:0]  iwrite_addr,
  output logic        oreg_write,
  output logic [4:0]  owrite_addr,
  output logic [31:0] owb_data,
  output logic [31:0] oPC,
  output logic [31:0] oIR,
  output logic        ovalid,
  output logic        omisaligned
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem_r [DEPTH];
  logic [ADDR_W-1:0] index_s;
  logic              misaligned_s;
  logic              store_en_s;
  logic [31:0]       load_data_s;
  logic [31:0]       pc_plus4_s;
  logic [31:0]       wb_data_s;

  // Address decode, alignment check and store qualification
  always_comb begin
    index_s      = ialu_res[ADDR_W+1:2];
    misaligned_s = (imem_read | imem_write) & (ialu_res[1:0] != 2'b00);
    store_en_s   = imem_write & ~misaligned_s & ~stall & ~flush & ~reset;
    load_data_s  = mem_r[index_s];
    pc_plus4_s   = iPC + 32'd4;
  end

  // Writeback value select; link address outranks loaded data
  always_comb begin
    wb_data_s = ialu_res;
    if (ipc_to_reg) begin
      wb_data_s = pc_plus4_s;
    end else if (imem_to_reg) begin
      wb_data_s = load_data_s;
    end else begin
      wb_data_s = ialu_res;
    end
  end

  // Data RAM write port; contents survive reset, reads see pre-edge data
  always_ff @(posedge clock) begin
    if (store_en_s) begin
      mem_r[index_s] <= iData_forMem;
    end
  end

  // MEM/WB pipeline register: reset > flush > stall > capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oreg_write  <= 1'b0;
      owrite_addr <= 5'd0;
      owb_data    <= 32'd0;
      oPC         <= 32'd0;
      oIR         <= 32'd0;
      ovalid      <= 1'b0;
      omisaligned <= 1'b0;
    end else if (flush) begin
      oreg_write  <= 1'b0;
      owrite_addr <= 5'd0;
      owb_data    <= 32'd0;
      oPC         <= 32'd0;
      oIR         <= 32'd0;
      ovalid      <= 1'b0;
      omisaligned <= 1'b0;
    end else if (!stall) begin
      oreg_write  <= ireg_write & ~misaligned_s;
      owrite_addr <= iwrite_addr;
      owb_data    <= wb_data_s;
      oPC         <= iPC;
      oIR         <= iIR;
      ovalid      <= 1'b1;
      omisaligned <= misaligned_s;
    end
  end

endmodule
